// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin arbiter sharing one iterative CORDIC core
// Optional: CORDIC_ARB_TIMEOUT_EN enables a done-wait timeout with resp_err reporting.
module cordic_arbiter #(
    parameter int     NREQ     = 4,
    parameter int     WIDTH    = 32,
    parameter int     ANGLE_W  = 32,
    parameter longint XIN_INIT = 1304065887,
    parameter int     TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*ANGLE_W-1:0]    req_angle,
    output logic [NREQ-1:0]            ack,
    output logic [WIDTH-1:0]           resp_cos,
    output logic [WIDTH-1:0]           resp_sin,
    output logic                       resp_err,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic [WIDTH-1:0]           cordic_xin,
    output logic [WIDTH-1:0]           cordic_yin,
    output logic [ANGLE_W-1:0]         cordic_angle,
    output logic                       cordic_start,
    input  logic [WIDTH-1:0]           cordic_cos,
    input  logic [WIDTH-1:0]           cordic_sin,
    input  logic                       cordic_done
);

    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("cordic_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_BUSY,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDW-1:0]   rr;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   cand;
    logic             pick_valid;
    logic             timed_out;

    assign cordic_xin = WIDTH'(XIN_INIT);
    assign cordic_yin = '0;
    assign busy       = (state != S_IDLE);

    // Scan from farthest to nearest so the requester just after rr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(rr) + k) % NREQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    logic [15:0] tcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (state == S_START) begin
            tcnt <= '0;
        end else if (state == S_ARM || state == S_BUSY) begin
            tcnt <= tcnt + 16'd1;
        end
    end

    assign timed_out = (state == S_BUSY) && !cordic_done && (tcnt >= 16'(TIMEOUT));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (pick_valid) state_nx = S_START;
            S_START: state_nx = S_ARM;
            S_ARM:   state_nx = S_BUSY;
            S_BUSY:  if (cordic_done || timed_out) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // start and ack are registered one state late, giving the 2-cycle latencies
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            rr           <= '0;
            grant_id     <= '0;
            cordic_angle <= '0;
            cordic_start <= 1'b0;
            ack          <= '0;
            resp_cos     <= '0;
            resp_sin     <= '0;
            resp_err     <= 1'b0;
        end else begin
            state        <= state_nx;
            cordic_start <= (state == S_START);
            ack          <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_id     <= pick;
                        cordic_angle <= req_angle[pick*ANGLE_W +: ANGLE_W];
                    end
                end
                S_BUSY: begin
                    if (cordic_done) begin
                        resp_cos <= cordic_cos;
                        resp_sin <= cordic_sin;
                        resp_err <= 1'b0;
                    end else if (timed_out) begin
                        resp_cos <= '0;
                        resp_sin <= '0;
                        resp_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (req[grant_id]) ack[grant_id] <= 1'b1;
                    rr <= grant_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - self-checking bench for cordic_arbiter with a behavioural CORDIC core
module tb_cordic_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int AW   = 32;
`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int TMO  = 50;
`else
    localparam int TMO  = 255;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*AW-1:0] req_angle = '0;
    logic [NREQ-1:0]    ack;
    logic [W-1:0]       resp_cos, resp_sin;
    logic               resp_err, busy;
    logic [1:0]         grant_id;
    logic [W-1:0]       cordic_xin, cordic_yin;
    logic [AW-1:0]      cordic_angle;
    logic               cordic_start;
    logic [W-1:0]       cordic_cos = '0;
    logic [W-1:0]       cordic_sin = '0;
    logic               cordic_done = 1'b0;

    int                 tests = 0;
    int                 fails = 0;
    int                 rr_ref = 0;
    logic [31:0]        angles [NREQ];
    bit                 core_en = 1'b1;
    int                 ccnt = 0;
    logic [31:0]        core_ang = '0;

    cordic_arbiter #(.NREQ(NREQ), .WIDTH(W), .ANGLE_W(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(rst_n), .req(req), .req_angle(req_angle),
        .ack(ack), .resp_cos(resp_cos), .resp_sin(resp_sin), .resp_err(resp_err),
        .busy(busy), .grant_id(grant_id), .cordic_xin(cordic_xin), .cordic_yin(cordic_yin),
        .cordic_angle(cordic_angle), .cordic_start(cordic_start),
        .cordic_cos(cordic_cos), .cordic_sin(cordic_sin), .cordic_done(cordic_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fcos(input logic [31:0] a);
        real r;
        r = $cos(real'(a) * 6.283185307179586 / 4294967296.0) * 1073741824.0;
        return 32'($rtoi(r < 0.0 ? r - 0.5 : r + 0.5));
    endfunction

    function automatic logic [31:0] fsin(input logic [31:0] a);
        real r;
        r = $sin(real'(a) * 6.283185307179586 / 4294967296.0) * 1073741824.0;
        return 32'($rtoi(r < 0.0 ? r - 0.5 : r + 0.5));
    endfunction

    // Core model: done 40 cycles after start, held until the next start.
    always @(posedge clk) begin
        if (cordic_start) begin
            cordic_done <= 1'b0;
            ccnt        <= 40;
            core_ang    <= cordic_angle;
        end else if (ccnt > 0) begin
            ccnt <= ccnt - 1;
            if (ccnt == 1 && core_en) begin
                cordic_done <= 1'b1;
                cordic_cos  <= fcos(core_ang);
                cordic_sin  <= fsin(core_ang);
            end
        end
    end

    function automatic int next_grant(input logic [3:0] m, input int r);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(r + k) % NREQ]) return (r + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_angles();
        for (int i = 0; i < NREQ; i++) req_angle[i*AW +: AW] = angles[i];
    endtask

    task automatic wait_start(output int c);
        c = 0;
        while (!cordic_start && c < 100) begin
            @(negedge clk);
            c++;
        end
    endtask

    // Called at the negedge where cordic_start is seen high.
    task automatic serve(input int id, input logic [3:0] clr, input logic [3:0] set_m);
        int c;
        bit early;
        logic [31:0] a;
        a = angles[id];
        chk("start_seen", cordic_start, 1'b1);
        chk("grant_id", grant_id, id);
        chk("cordic_angle", cordic_angle, a);
        angles[id] = $urandom;
        drive_angles();
        early = 0;
        c = 0;
        while (cordic_done && c < 10) begin
            @(negedge clk);
            c++;
            if (ack != 0) early = 1;
        end
        c = 0;
        while (!cordic_done && c < 200) begin
            @(negedge clk);
            c++;
            if (ack != 0) early = 1;
        end
        chk("no_early_ack", early, 0);
        c = 0;
        while (ack == 0 && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("done_to_ack", c, 2);
        chk("ack_onehot", ack, 4'b0001 << id);
        chk("resp_cos", resp_cos, fcos(a));
        chk("resp_sin", resp_sin, fsin(a));
        chk("resp_err", resp_err, 0);
        req = (req & ~clr) | set_m;
        rr_ref = id;
        @(negedge clk);
        chk("ack_one_cycle", ack, 0);
    endtask

    initial begin
        int c, d, g;
        bit seen;
        logic [3:0] pend, nb;

        for (int i = 0; i < NREQ; i++) angles[i] = $urandom;
        drive_angles();

        // 1: reset held with all requesting
        rst_n = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_outs", {ack, busy, grant_id, cordic_angle, cordic_start, resp_err}, 0);
        end
        chk("reset_cos_sin", {resp_cos, resp_sin}, 0);
        chk("xin_const", cordic_xin, 32'd1304065887);
        chk("yin_const", cordic_yin, 0);
        req = 4'b0000;
        rst_n = 1'b1;
        rr_ref = 0;
        @(negedge clk);

        // 2: single request at 45 degrees
        angles[2] = 32'h2000_0000;
        drive_angles();
        req = 4'b0100;
        wait_start(c);
        chk("req_to_start", c, 2);
        serve(2, 4'b0100, 4'b0000);
        d = int'(resp_cos) - 759250125;
        chk("cos45_close", (d <= 4 && d >= -4), 1);
        d = int'(resp_sin) - 759250125;
        chk("sin45_close", (d <= 4 && d >= -4), 1);
        chk("busy_idle", busy, 0);

        // 4: stale done still high from previous op
        chk("stale_done_high", cordic_done, 1);
        req = 4'b0001;
        wait_start(c);
        serve(next_grant(4'b0001, rr_ref), 4'b0001, 4'b0000);

        // 3: round robin from a clean reset, all requesting
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_ref = 0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = next_grant(4'b1111, rr_ref);
            wait_start(c);
            serve(g, (k == 4) ? 4'b1111 : 4'b0000, 4'b0000);
        end
        chk("rr_last_grant", rr_ref, 1);

        // random pending sets against the round-robin reference
        pend = 4'($urandom_range(1, 15));
        req = pend;
        for (int k = 0; k < 8; k++) begin
            g = next_grant(pend, rr_ref);
            nb = 4'($urandom_range(0, 15));
            if (k == 7) begin
                pend = 4'b0000;
                nb   = 4'b0000;
            end else begin
                pend = pend & ~(4'b0001 << g);
                if ((pend | nb) == 0) nb = 4'b0001 << $urandom_range(0, 3);
                pend = pend | nb;
            end
            wait_start(c);
            serve(g, (k == 7) ? 4'b1111 : (4'b0001 << g), nb);
        end
        repeat (3) @(negedge clk);

        // 5: requester drops during BUSY
        req = 4'b1000;
        wait_start(c);
        chk("drop_grant", grant_id, 3);
        repeat (10) @(negedge clk);
        req = 4'b0000;
        seen = 0;
        c = 0;
        while (busy && c < 200) begin
            @(negedge clk);
            c++;
            if (ack != 0) seen = 1;
        end
        repeat (3) begin
            @(negedge clk);
            if (ack != 0) seen = 1;
        end
        chk("drop_no_ack", seen, 0);
        chk("drop_busy_fell", busy, 0);
        rr_ref = 3;
        req = 4'b1111;
        wait_start(c);
        serve(next_grant(4'b1111, rr_ref), 4'b1111, 4'b0000);
        repeat (3) @(negedge clk);

        // 6: core never finishes
        core_en = 1'b0;
        req = 4'b0100;
        wait_start(c);
        seen = 0;
        c = 0;
        while (ack == 0 && c < 300) begin
            @(negedge clk);
            c++;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        chk("tmo_ack", ack, 4'b0100);
        chk("tmo_window", (c >= 45 && c <= 60), 1);
        chk("tmo_err", resp_err, 1);
        chk("tmo_cos_sin", {resp_cos, resp_sin}, 0);
        req = 4'b0000;
        rr_ref = 2;
        repeat (3) @(negedge clk);
        core_en = 1'b1;
        req = 4'b1000;
        wait_start(c);
        repeat (10) @(negedge clk);
`else
        chk("no_tmo_ack", ack, 0);
        chk("no_tmo_busy", busy, 1);
        req = 4'b0000;
        core_en = 1'b1;
`endif

        // 7: reset mid-operation, then normal service
        chk("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outs", {ack, busy, grant_id, cordic_angle, cordic_start, resp_err}, 0);
        chk("midreset_cos_sin", {resp_cos, resp_sin}, 0);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rr_ref = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (cordic_start) seen = 1;
        end
        chk("no_restart", seen, 0);
        angles[1] = $urandom;
        drive_angles();
        req = 4'b0010;
        wait_start(c);
        chk("post_reset_start", c, 2);
        serve(1, 4'b0010, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
